// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - Moore control sequencer for a shift-and-add multiplier datapath
//
// Purpose:
//   Steps the multiplier datapath through LOAD, then WIDTH iterations of
//   TEST / (ADD) / SHIFT, then a one-cycle DONE. The iteration counter is kept
//   here, so the datapath only has to supply the current multiplier LSB.
//
// Parameters:
//   WIDTH    operand width and number of iterations (2..32)
//   CW       counter width, derived from WIDTH
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    begin a multiplication (only looked at in IDLE)
//   abort    synchronous cancel back to IDLE, clears cnt
//   q_lsb    LSB of the datapath multiplier/product register
//   ld_en    load operands, clear accumulator (LOAD)
//   add_en   add multiplicand into accumulator (ADD)
//   sh_en    shift product/multiplier right by one (SHIFT)
//   busy     high in every state except IDLE
//   done     one-cycle completion pulse (DONE)
//   cnt      remaining iterations
//   state_o  current state encoding, for debug

module mult_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          q_lsb,
    output logic          ld_en,
    output logic          add_en,
    output logic          sh_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_TEST  = 3'b010,
        S_ADD   = 3'b011,
        S_SHIFT = 3'b100,
        S_DONE  = 3'b101
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
            S_LOAD: begin
                state_d = S_TEST;
                cnt_d   = CW'(WIDTH);
            end
            S_TEST:  state_d = q_lsb ? S_ADD : S_SHIFT;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: begin
                // Guard keeps cnt from wrapping even if it were somehow 0 here.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                state_d = (cnt_q <= CW'(1)) ? S_DONE : S_TEST;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over every transition out of a non-IDLE state.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        ld_en  = (state_q == S_LOAD);
        add_en = (state_q == S_ADD);
        sh_en  = (state_q == S_SHIFT);
        done   = (state_q == S_DONE);
        busy   = (state_q != S_IDLE);
    end

    assign cnt     = cnt_q;
    assign state_o = state_q;

endmodule
